// File: rtl/io_input_debounce.sv
// Two-flop synchronizer plus per-bit debounce filter for the 8 raw switch/key pins feeding io_input_reg.
// Define IO_DEBOUNCE_EDGE_EN to add the chg_port0/chg_port1 one-cycle change pulses.
module io_input_debounce #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic       io_clk,
  input  logic       resetn,
  input  logic [3:0] raw_port0,
  input  logic [3:0] raw_port1,
  output logic [3:0] in_port0,
  output logic [3:0] in_port1
`ifdef IO_DEBOUNCE_EDGE_EN
  ,
  output logic [3:0] chg_port0,
  output logic [3:0] chg_port1
`endif
);

  localparam int NCH = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NCH-1:0]   raw_s;
  logic [NCH-1:0]   sync1_q;
  logic [NCH-1:0]   sync2_q;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  assign raw_s = {raw_port1, raw_port0};

  // Per-channel filter: count consecutive mismatches, adopt sync2 after DEB_CYCLES of them.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Synchronizer, stable and counter state.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= raw_s;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign in_port0 = stable_q[3:0];
  assign in_port1 = stable_q[7:4];

`ifdef IO_DEBOUNCE_EDGE_EN
  logic [NCH-1:0] chg_q;

  // Change pulse is captured on the same edge the stable bit flips.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      chg_q <= '0;
    end else begin
      chg_q <= stable_q ^ stable_d;
    end
  end

  assign chg_port0 = chg_q[3:0];
  assign chg_port1 = chg_q[7:4];
`endif

endmodule

// File: tb/tb_io_input_debounce.sv
// Self-checking bench for io_input_debounce: directed vector table, hand sequences and random stimulus
// against a sliding-window reference model; instances at DEB_CYCLES=16 and DEB_CYCLES=1.
module tb_io_input_debounce;

  logic       io_clk;
  logic       resetn;
  logic [3:0] raw_port0;
  logic [3:0] raw_port1;
  logic [3:0] in0_a, in1_a, in0_b, in1_b;
`ifdef IO_DEBOUNCE_EDGE_EN
  logic [3:0] chg0_a, chg1_a, chg0_b, chg1_b;
`endif

  int checks = 0;
  int errors = 0;

  io_input_debounce #(.DEB_CYCLES(16), .CNT_W(5)) dut (
    .io_clk(io_clk), .resetn(resetn),
    .raw_port0(raw_port0), .raw_port1(raw_port1),
    .in_port0(in0_a), .in_port1(in1_a)
`ifdef IO_DEBOUNCE_EDGE_EN
    , .chg_port0(chg0_a), .chg_port1(chg1_a)
`endif
  );

  io_input_debounce #(.DEB_CYCLES(1), .CNT_W(5)) dut1 (
    .io_clk(io_clk), .resetn(resetn),
    .raw_port0(raw_port0), .raw_port1(raw_port1),
    .in_port0(in0_b), .in_port1(in1_b)
`ifdef IO_DEBOUNCE_EDGE_EN
    , .chg_port0(chg0_b), .chg_port1(chg1_b)
`endif
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  // Reference model: sync2 is raw delayed two edges; a bit flips once the last N sync2 samples all oppose it.
  logic [7:0] rawh [2];
  logic [7:0] hist [16];
  logic [7:0] st16, st1, chg16, chg1;

  task automatic model_reset();
    rawh[0] = 8'h00; rawh[1] = 8'h00;
    for (int i = 0; i < 16; i++) hist[i] = 8'h00;
    st16 = 8'h00; st1 = 8'h00; chg16 = 8'h00; chg1 = 8'h00;
  endtask

  task automatic model_edge(input logic [7:0] r);
    logic [7:0] s2;
    logic [7:0] all16;
    s2 = rawh[1];
    rawh[1] = rawh[0];
    rawh[0] = r;
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s2;
    all16 = 8'hFF;
    for (int i = 0; i < 16; i++) all16 = all16 & (hist[i] ^ st16);
    chg16 = all16;
    st16  = st16 ^ all16;
    chg1  = hist[0] ^ st1;
    st1   = st1 ^ chg1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("m16_p0", in0_a, st16[3:0]);
    chk("m16_p1", in1_a, st16[7:4]);
    chk("m1_p0", in0_b, st1[3:0]);
    chk("m1_p1", in1_b, st1[7:4]);
`ifdef IO_DEBOUNCE_EDGE_EN
    chk("c16_p0", chg0_a, chg16[3:0]);
    chk("c16_p1", chg1_a, chg16[7:4]);
    chk("c1_p0", chg0_b, chg1[3:0]);
    chk("c1_p1", chg1_b, chg1[7:4]);
`endif
  endtask

  task automatic tick(input logic [3:0] r0, input logic [3:0] r1);
    raw_port0 = r0;
    raw_port1 = r1;
    @(posedge io_clk);
    if (resetn) model_edge({r1, r0});
    else model_reset();
    #1;
    cmp_model();
  endtask

  typedef struct packed {
    logic [3:0]  r0;
    logic [3:0]  r1;
    int unsigned n;
    logic [3:0]  e0;
    logic [3:0]  e1;
  } vec_t;

  vec_t vecs [15];
  logic [7:0] cur;

  initial begin
    vecs[0]  = '{4'hF, 4'hA, 17, 4'h0, 4'h0};
    vecs[1]  = '{4'hF, 4'hA, 1,  4'hF, 4'hA};
    vecs[2]  = '{4'h0, 4'h0, 17, 4'hF, 4'hA};
    vecs[3]  = '{4'h0, 4'h0, 1,  4'h0, 4'h0};
    vecs[4]  = '{4'h4, 4'h0, 17, 4'h0, 4'h0};
    vecs[5]  = '{4'h4, 4'h0, 1,  4'h4, 4'h0};
    vecs[6]  = '{4'h4, 4'h1, 15, 4'h4, 4'h0};
    vecs[7]  = '{4'h4, 4'h0, 20, 4'h4, 4'h0};
    vecs[8]  = '{4'h4, 4'h1, 16, 4'h4, 4'h0};
    vecs[9]  = '{4'h4, 4'h0, 1,  4'h4, 4'h0};
    vecs[10] = '{4'h4, 4'h0, 1,  4'h4, 4'h1};
    vecs[11] = '{4'h4, 4'h0, 15, 4'h4, 4'h1};
    vecs[12] = '{4'h4, 4'h0, 1,  4'h4, 4'h0};
    vecs[13] = '{4'h5, 4'h3, 17, 4'h4, 4'h0};
    vecs[14] = '{4'h5, 4'h3, 1,  4'h5, 4'h3};

    resetn = 1'b0;
    raw_port0 = 4'hF;
    raw_port1 = 4'hA;
    model_reset();
    #1;
    chk("rst_async_p0", in0_a, 4'h0);
    chk("rst_async_p1", in1_a, 4'h0);
    for (int c = 0; c < 3; c++) begin
      tick(4'hF, 4'hA);
      chk("rst_hold_p0", in0_a, 4'h0);
      chk("rst_hold_p1", in1_a, 4'h0);
    end
    resetn = 1'b1;

    for (int v = 0; v < 15; v++) begin
      for (int c = 0; c < int'(vecs[v].n); c++) tick(vecs[v].r0, vecs[v].r1);
      chk($sformatf("vec%0d_p0", v), in0_a, vecs[v].e0);
      chk($sformatf("vec%0d_p1", v), in1_a, vecs[v].e1);
    end

    // Reset mid-count: bit3 counting when reset hits, then a full re-qualification.
    for (int c = 0; c < 12; c++) tick(4'h8, 4'h0);
    chk("midcnt_pre_p0", in0_a, 4'h5);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("midcnt_rst_p0", in0_a, 4'h0);
    chk("midcnt_rst_p1", in1_a, 4'h0);
    tick(4'h8, 4'h0);
    resetn = 1'b1;
    for (int c = 0; c < 17; c++) tick(4'h8, 4'h0);
    chk("midcnt_17_p0", in0_a, 4'h0);
    tick(4'h8, 4'h0);
    chk("midcnt_18_p0", in0_a, 4'h8);

    // Bit1 bounces every 3 cycles while bit0 and group 1 make a clean change.
    for (int i = 0; i < 18; i++) begin
      tick(4'h9 | (((i / 3) % 2) != 0 ? 4'h2 : 4'h0), 4'h3);
      if (i == 16) begin
        chk("bounce16_p0", in0_a, 4'h8);
        chk("bounce16_p1", in1_a, 4'h0);
      end
      if (i == 17) begin
        chk("bounce17_p0", in0_a, 4'h9);
        chk("bounce17_p1", in1_a, 4'h3);
      end
    end

    // DEB_CYCLES=1 instance: one-cycle raw pulse and a held level.
    for (int c = 0; c < 20; c++) tick(4'h0, 4'h0);
    tick(4'h1, 4'h0);
    tick(4'h0, 4'h0);
    chk("d1_pulse_e1", in0_b, 4'h0);
    tick(4'h0, 4'h0);
    chk("d1_pulse_e2", in0_b, 4'h1);
    tick(4'h0, 4'h0);
    chk("d1_pulse_e3", in0_b, 4'h0);
    tick(4'h0, 4'h2);
    tick(4'h0, 4'h2);
    chk("d1_level_e1", in1_b, 4'h0);
    tick(4'h0, 4'h2);
    chk("d1_level_e2", in1_b, 4'h2);

    // Random per-bit toggling with occasional reset, checked against the model every edge.
    cur = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(13) == 0) cur[b] = ~cur[b];
      end
      if (c == 700) resetn = 1'b0;
      if (c == 703) resetn = 1'b1;
      tick(cur[3:0], cur[7:4]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_debounce.md
Name: io_input_debounce

Overview:
- Conditions raw board switch/key inputs before io_input_reg samples them: 2-flop synchronizer plus per-bit debounce filter.
- Produces the stable 4-bit in_port0/in_port1 buses consumed by io_input_reg.
- Sits between top-level pins and io_input_reg, and runs on the same io_clk.

Parameters:
- DEB_CYCLES, 16, consecutive io_clk cycles a synchronized bit must differ from its stable value before the stable value updates; legal range 1..2^CNT_W-1.
- CNT_W, 5, width of each per-bit debounce counter.

Ports:
- io_clk  input  1  I/O clock, rising-edge active.
- resetn  input  1  asynchronous active-low reset.
- raw_port0  input  4  unsynchronized switch/key inputs, group 0.
- raw_port1  input  4  unsynchronized switch/key inputs, group 1.
- in_port0  output  4  debounced stable value, group 0; feeds io_input_reg.
- in_port1  output  4  debounced stable value, group 1; feeds io_input_reg.
- chg_port0  output  4  one-cycle change pulse per bit, group 0; present only with IO_DEBOUNCE_EDGE_EN.
- chg_port1  output  4  one-cycle change pulse per bit, group 1; present only with IO_DEBOUNCE_EDGE_EN.

Behaviour:
- Clock and reset: one clock, io_clk; reset is asynchronous and active-low (resetn).
- Reset (resetn=0, asynchronous assert): all sync flops, stable bits and counters clear to 0. in_port0=in_port1=4'h0; chg_port* = 0.
- Release: synchronous to io_clk; first active edge is the first edge with resetn=1.
- Bits: 8 independent channels (4 per group), each with sync1 -> sync2 -> stable plus a CNT_W counter.
- Per edge, each channel:
  - sync1 <= raw; sync2 <= sync1.
  - If sync2 == stable: cnt <= 0.
  - If sync2 != stable and cnt != DEB_CYCLES-1: cnt <= cnt+1.
  - If sync2 != stable and cnt == DEB_CYCLES-1: stable <= sync2; cnt <= 0.
- Latency: raw level set up before edge 0 and held -> sync2 changes after edge 1 -> stable/in_port changes at edge 1+DEB_CYCLES (edge 17 at default).
- Glitch rejection: any mismatch run shorter than DEB_CYCLES cycles at sync2 clears the counter and leaves stable unchanged. A run of exactly DEB_CYCLES cycles is accepted.
- DEB_CYCLES=1: stable follows sync2 one edge later (latency 2 edges from raw).
- Counter never exceeds DEB_CYCLES-1; no wrap-around possible.
- Simultaneous events: channels are fully independent; any set of bits may update on the same edge.
- Reset mid-count: counter and stable clear immediately; a held raw 1 then requires a full 1+DEB_CYCLES edges after release.
- in_port* are registered outputs (stable flops directly); no combinational path from raw_port*.

Optional Feature:
- Macro: IO_DEBOUNCE_EDGE_EN.
- Defined: chg_port0/chg_port1 exist. The bit is registered high for exactly one cycle following the edge on which the corresponding stable bit flips (either direction); otherwise 0. Reset value 0.
- Not defined: chg_port* ports and their flops are absent; in_port* behaviour is identical in both builds.

Test Plan:
- Reset: resetn=0 with raw_port0=4'hF, raw_port1=4'hA -> in_port0=in_port1=4'h0 throughout reset; after release and DEB_CYCLES=16 -> in_port0=4'hF, in_port1=4'hA at edge 17 after release, not edge 16.
- Clean press: raw_port0 bit2 0->1 held -> in_port0=4'h4 exactly at edge 17; with IO_DEBOUNCE_EDGE_EN, chg_port0=4'h4 for one cycle after that edge only.
- Glitch: raw_port1 bit0 high for 15 cycles then low -> in_port1 stays 4'h0; a subsequent 16-cycle high pulse -> in_port1=4'h1, then back to 4'h0 16 cycles after the low is synchronized.
- Simultaneous and independent: raw_port0=4'h5 and raw_port1=4'h3 change on the same cycle -> both outputs update on the same edge. Bit1 of group 0 bouncing every 3 cycles -> does not delay or affect other bits.
- Reset mid-count: raw_port0 bit3 high, assert resetn at cycle 10 of count, release -> in_port0=4'h0 until a full 17 edges after release, then 4'h8.
- DEB_CYCLES=1 build: raw bit toggle held -> output follows 2 edges later; a 1-cycle raw pulse sampled by sync1 -> propagates as a 1-cycle in_port pulse.
